// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host receive front-end: synchronise, glitch-filter, deserialise
// the 11-bit frame and report good bytes or frame/parity errors as strobes.
`timescale 1ns/1ps
module ps2_rx_frame #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic       clk25,
  input  logic       rst_n,
  input  logic       key_clk,
  input  logic       key_din,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned FW = 8;
  localparam int unsigned TW = 16;
  localparam int unsigned BW = 3;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]    clk_sync;
  logic [1:0]    din_sync;
  logic          clk_s;
  logic          bit_in;
  logic          filt;
  logic          filt_prev;
  logic [FW-1:0] fcnt;
  logic          fe;
  state_t        state;
  logic [BW-1:0] bitcnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tcnt;

  assign clk_s  = clk_sync[1];
  assign bit_in = din_sync[1];
  assign fe     = filt_prev & ~filt;
  assign busy   = (state != S_IDLE);

  // Two-flop synchronisers; the idle bus level is high
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= 2'b11;
      din_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], key_clk};
      din_sync <= {din_sync[0], key_din};
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      filt      <= 1'b1;
      filt_prev <= 1'b1;
      fcnt      <= '0;
    end else begin
      filt_prev <= filt;
      if (clk_s != filt) begin
        if (fcnt == FW'(FILTER_LEN - 1)) begin
          filt <= clk_s;
          fcnt <= '0;
        end else begin
          fcnt <= fcnt + FW'(1);
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  // Frame FSM; steps on filtered falling edges, timeout abandons a stalled frame
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      bitcnt     <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      tcnt       <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (fe) begin
        tcnt <= '0;
        case (state)
          S_IDLE: begin
            if (!bit_in) begin
              state  <= S_DATA;
              bitcnt <= '0;
            end
          end
          S_DATA: begin
            shreg  <= {bit_in, shreg[7:1]};
            bitcnt <= bitcnt + BW'(1);
            if (bitcnt == BW'(7)) state <= S_PARITY;
          end
          S_PARITY: begin
            par   <= bit_in;
            state <= S_STOP;
          end
          S_STOP: begin
            state  <= S_IDLE;
            bitcnt <= '0;
            if (!bit_in) begin
              frame_err <= 1'b1;
            end else if (^{shreg, par}) begin
              code       <= shreg;
              code_valid <= 1'b1;
            end else begin
              parity_err <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end else if (state == S_IDLE) begin
        tcnt <= '0;
      end else if (tcnt == TW'(TIMEOUT - 2)) begin
        // Counter reaches TIMEOUT-1 on this edge: abandon the frame
        state     <= S_IDLE;
        bitcnt    <= '0;
        tcnt      <= '0;
        frame_err <= 1'b1;
      end else begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame: good, parity, stop, timeout, glitch,
// back-to-back and mid-frame reset scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_ps2_rx_frame;

  localparam int FL   = 8;
  localparam int TO   = 300;
  localparam int HALF = 40;

  logic       clk25 = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_clk = 1'b1;
  logic       key_din = 1'b1;
  logic [7:0] code;
  logic       code_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int last_fall = 0;
  int cv_cnt = 0, pe_cnt = 0, fr_cnt = 0, dbl_cnt = 0, ovl_cnt = 0;
  int cv_cyc = 0, fr_cyc = 0;
  logic cv_d = 1'b0, pe_d = 1'b0, fr_d = 1'b0;
  logic [7:0] codes[$];

  ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk25(clk25), .rst_n(rst_n), .key_clk(key_clk), .key_din(key_din),
    .code(code), .code_valid(code_valid), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy)
  );

  always #20 clk25 = ~clk25;

  always @(posedge clk25) cyc <= cyc + 1;

  // Strobe monitor: counts, timestamps, pulse widths and exclusivity
  always @(negedge clk25) begin
    if (code_valid) begin
      cv_cnt <= cv_cnt + 1;
      cv_cyc <= cyc;
      codes.push_back(code);
    end
    if (parity_err) pe_cnt <= pe_cnt + 1;
    if (frame_err) begin
      fr_cnt <= fr_cnt + 1;
      fr_cyc <= cyc;
    end
    if ((code_valid && cv_d) || (parity_err && pe_d) || (frame_err && fr_d))
      dbl_cnt <= dbl_cnt + 1;
    if ($countones({code_valid, parity_err, frame_err}) > 1) ovl_cnt <= ovl_cnt + 1;
    cv_d <= code_valid;
    pe_d <= parity_err;
    fr_d <= frame_err;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk25);
  endtask

  task automatic send_bit(input logic b);
    key_din = b;
    repeat (HALF) @(negedge clk25);
    key_clk = 1'b0;
    last_fall = cyc;
    repeat (HALF) @(negedge clk25);
    key_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ par_flip);
    send_bit(stop);
    key_din = 1'b1;
  endtask

  task automatic glitch();
    key_clk = 1'b0;
    repeat (FL - 1) @(negedge clk25);
    key_clk = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(5);
    compared++; if (code !== 8'h00) begin mismatched++; $display("FAIL reset_code: got %h want 00", code); end
    compared++; if (code_valid !== 1'b0) begin mismatched++; $display("FAIL reset_code_valid: got %b want 0", code_valid); end
    compared++; if (parity_err !== 1'b0) begin mismatched++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
    compared++; if (frame_err !== 1'b0) begin mismatched++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    idle(5);
  endtask

  task automatic test_parity_err();
    int bcv, bpe, bfr;
    bcv = cv_cnt; bpe = pe_cnt; bfr = fr_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
    idle(FL + 10);
    compared++; if (pe_cnt - bpe !== 1) begin mismatched++; $display("FAIL parity_err_count: got %0d want 1", pe_cnt - bpe); end
    compared++; if (cv_cnt - bcv !== 0) begin mismatched++; $display("FAIL parity_no_valid: got %0d want 0", cv_cnt - bcv); end
    compared++; if (fr_cnt - bfr !== 0) begin mismatched++; $display("FAIL parity_no_frame_err: got %0d want 0", fr_cnt - bfr); end
    compared++; if (code !== 8'h00) begin mismatched++; $display("FAIL parity_code_held: got %h want 00", code); end
  endtask

  task automatic test_good_frame();
    int bcv, bpe, bfr;
    bcv = cv_cnt; bpe = pe_cnt; bfr = fr_cnt;
    send_frame(8'h1C, 1'b0, 1'b1);
    idle(FL + 10);
    compared++; if (cv_cnt - bcv !== 1) begin mismatched++; $display("FAIL good_valid_count: got %0d want 1", cv_cnt - bcv); end
    compared++; if (code !== 8'h1C) begin mismatched++; $display("FAIL good_code: got %h want 1c", code); end
    compared++; if (cv_cyc - last_fall !== FL + 3) begin mismatched++; $display("FAIL good_latency: got %0d want %0d", cv_cyc - last_fall, FL + 3); end
    compared++; if ((pe_cnt - bpe) + (fr_cnt - bfr) !== 0) begin mismatched++; $display("FAIL good_no_errors: got %0d want 0", (pe_cnt - bpe) + (fr_cnt - bfr)); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL good_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_stop_err();
    int bcv, bpe, bfr;
    bcv = cv_cnt; bpe = pe_cnt; bfr = fr_cnt;
    send_frame(8'hF0, 1'b0, 1'b0);
    idle(FL + 10);
    compared++; if (fr_cnt - bfr !== 1) begin mismatched++; $display("FAIL stop_frame_err: got %0d want 1", fr_cnt - bfr); end
    compared++; if ((cv_cnt - bcv) + (pe_cnt - bpe) !== 0) begin mismatched++; $display("FAIL stop_other_strobes: got %0d want 0", (cv_cnt - bcv) + (pe_cnt - bpe)); end
    compared++; if (code !== 8'h1C) begin mismatched++; $display("FAIL stop_code_held: got %h want 1c", code); end
    bcv = cv_cnt;
    send_frame(8'h1C, 1'b0, 1'b1);
    idle(FL + 10);
    compared++; if (cv_cnt - bcv !== 1) begin mismatched++; $display("FAIL stop_recover_valid: got %0d want 1", cv_cnt - bcv); end
    compared++; if (codes[$] !== 8'h1C) begin mismatched++; $display("FAIL stop_recover_code: got %h want 1c", codes[$]); end
  endtask

  task automatic test_timeout();
    int bcv, bfr;
    bcv = cv_cnt; bfr = fr_cnt;
    send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    key_din = 1'b1;
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL timeout_busy_mid: got %b want 1", busy); end
    for (int i = 0; i < TO + 100 && fr_cnt == bfr; i++) @(negedge clk25);
    idle(2);
    compared++; if (fr_cnt - bfr !== 1) begin mismatched++; $display("FAIL timeout_frame_err: got %0d want 1", fr_cnt - bfr); end
    compared++; if (fr_cyc - last_fall !== FL + 2 + TO) begin mismatched++; $display("FAIL timeout_delay: got %0d want %0d", fr_cyc - last_fall, FL + 2 + TO); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL timeout_busy_after: got %b want 0", busy); end
    send_frame(8'h5A, 1'b0, 1'b1);
    idle(FL + 10);
    compared++; if (cv_cnt - bcv !== 1) begin mismatched++; $display("FAIL timeout_recover_valid: got %0d want 1", cv_cnt - bcv); end
    compared++; if (code !== 8'h5A) begin mismatched++; $display("FAIL timeout_recover_code: got %h want 5a", code); end
  endtask

  task automatic test_glitch();
    int bcv, bpe, bfr;
    logic [7:0] d;
    bcv = cv_cnt; bpe = pe_cnt; bfr = fr_cnt;
    d = 8'h76;
    key_din = 1'b0;
    glitch();
    idle(FL + 10);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL glitch_idle_busy: got %b want 0", busy); end
    key_din = 1'b1;
    idle(4);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i]);
      if (i == 3) begin
        idle(10);
        glitch();
      end
    end
    send_bit(~^d);
    send_bit(1'b1);
    idle(FL + 10);
    compared++; if (cv_cnt - bcv !== 1) begin mismatched++; $display("FAIL glitch_valid_count: got %0d want 1", cv_cnt - bcv); end
    compared++; if (code !== 8'h76) begin mismatched++; $display("FAIL glitch_code: got %h want 76", code); end
    compared++; if ((pe_cnt - bpe) + (fr_cnt - bfr) !== 0) begin mismatched++; $display("FAIL glitch_no_errors: got %0d want 0", (pe_cnt - bpe) + (fr_cnt - bfr)); end
  endtask

  task automatic test_back_to_back();
    int bcv, bq;
    bcv = cv_cnt; bq = codes.size();
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    idle(FL + 10);
    compared++; if (cv_cnt - bcv !== 2) begin mismatched++; $display("FAIL b2b_valid_count: got %0d want 2", cv_cnt - bcv); end
    if (codes.size() >= bq + 2) begin
      compared++; if (codes[bq] !== 8'hF0) begin mismatched++; $display("FAIL b2b_first: got %h want f0", codes[bq]); end
      compared++; if (codes[bq + 1] !== 8'h1C) begin mismatched++; $display("FAIL b2b_second: got %h want 1c", codes[bq + 1]); end
    end
  endtask

  task automatic test_reset_mid();
    int bcv, bpe, bfr;
    bcv = cv_cnt; bpe = pe_cnt; bfr = fr_cnt;
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    key_din = 1'b1;
    @(negedge clk25);
    rst_n = 1'b0;
    #1;
    compared++; if (code !== 8'h00) begin mismatched++; $display("FAIL rstmid_code: got %h want 00", code); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    compared++; if ({code_valid, parity_err, frame_err} !== 3'b000) begin mismatched++; $display("FAIL rstmid_strobes: got %b want 000", {code_valid, parity_err, frame_err}); end
    idle(5);
    rst_n = 1'b1;
    idle(TO + 20);
    compared++; if ((cv_cnt - bcv) + (pe_cnt - bpe) + (fr_cnt - bfr) !== 0) begin mismatched++; $display("FAIL rstmid_no_strobe: got %0d want 0", (cv_cnt - bcv) + (pe_cnt - bpe) + (fr_cnt - bfr)); end
    send_frame(8'h29, 1'b0, 1'b1);
    idle(FL + 10);
    compared++; if (cv_cnt - bcv !== 1) begin mismatched++; $display("FAIL rstmid_recover_valid: got %0d want 1", cv_cnt - bcv); end
    compared++; if (code !== 8'h29) begin mismatched++; $display("FAIL rstmid_recover_code: got %h want 29", code); end
  endtask

  task automatic test_strobe_shape();
    compared++; if (dbl_cnt !== 0) begin mismatched++; $display("FAIL strobe_width: got %0d long pulses want 0", dbl_cnt); end
    compared++; if (ovl_cnt !== 0) begin mismatched++; $display("FAIL strobe_exclusive: got %0d overlaps want 0", ovl_cnt); end
  endtask

  initial begin
    test_reset();
    test_parity_err();
    test_good_frame();
    test_stop_err();
    test_timeout();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_strobe_shape();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
